// File: rtl/pack_rq0_pkg.sv
// Shared parameters and types for the Rq0 polynomial packer.
package pack_rq0_pkg;
  localparam int N          = 701;
  localparam int LOGQ       = 13;
  localparam int PACK_BYTES = ((N - 1) * LOGQ + 7) / 8;
  localparam int BUF_W      = LOGQ + 7;
  localparam int CNT_W      = $clog2(N + 1);
  localparam int BCNT_W     = $clog2(BUF_W + 1);
  localparam int BYTE_CNT_W = $clog2(PACK_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    FIN   = 2'd3
  } state_t;
endpackage

// File: rtl/pack_rq0_if.sv
// Handshake bundle between a coefficient producer / byte consumer and the packer.
interface pack_rq0_if;
  import pack_rq0_pkg::*;

  logic            start;
  logic [LOGQ-1:0] coef;
  logic            coef_valid;
  logic            coef_ready;
  logic [7:0]      byte_out;
  logic            byte_valid;
  logic            byte_ready;
  logic            busy;
  logic            done;
  logic            sum_ok;

  // Producer/consumer side.
  modport master (
    output start, coef, coef_valid, byte_ready,
    input  coef_ready, byte_out, byte_valid, busy, done, sum_ok
  );

  // Packer side.
  modport slave (
    input  start, coef, coef_valid, byte_ready,
    output coef_ready, byte_out, byte_valid, busy, done, sum_ok
  );
endinterface

// File: rtl/pack_rq0_bitbuf.sv
// Little-endian bit accumulator: coefficients are OR-ed in above the current
// fill level and whole bytes are shifted out from the bottom.
module pack_bitbuf
  import pack_rq0_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [LOGQ-1:0]   i_data,
  input  logic              i_shift8,
  output logic [7:0]        o_byte,
  output logic [BCNT_W-1:0] o_bitcnt
);
  logic [BUF_W-1:0]  r_buf;
  logic [BCNT_W-1:0] r_bitcnt;
  logic [BUF_W-1:0]  w_ins;

  // Loads only happen with fewer than 8 bits held, so the shifted value fits.
  assign w_ins = BUF_W'(i_data) << r_bitcnt;

  // Buffer and fill level; bits above the fill level are always zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf    <= '0;
      r_bitcnt <= '0;
    end else if (i_clear) begin
      r_buf    <= '0;
      r_bitcnt <= '0;
    end else if (i_load) begin
      r_buf    <= r_buf | w_ins;
      r_bitcnt <= r_bitcnt + BCNT_W'(LOGQ);
    end else if (i_shift8) begin
      r_buf    <= r_buf >> 8;
      // The final partial byte leaves fewer than 8 bits; it drains to empty.
      r_bitcnt <= (r_bitcnt >= BCNT_W'(8)) ? (r_bitcnt - BCNT_W'(8)) : '0;
    end
  end

  assign o_byte   = r_buf[7:0];
  assign o_bitcnt = r_bitcnt;
endmodule

// File: rtl/pack_rq0.sv
// Rq0 packer: streams N-1 coefficients as a little-endian byte string and
// checks that all N coefficients sum to zero mod 2^LOGQ.
module pack_rq0
  import pack_rq0_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  pack_rq0_if.slave  bus
);
  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_coef_cnt;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [LOGQ-1:0]       r_sum;
  logic                  r_sum_ok;

  logic [7:0]            w_buf_byte;
  logic [BCNT_W-1:0]     w_bitcnt;
  logic                  w_coef_ready;
  logic                  w_byte_valid;
  logic                  w_start_go;
  logic                  w_all_in;
  logic                  w_coef_acc;
  logic                  w_byte_hs;
  logic                  w_load;
  logic                  w_enter_fin;

  assign w_all_in = (r_coef_cnt == CNT_W'(N));

  // Next-state and handshake qualifiers.
  always_comb begin
    w_state_next = r_state;
    w_coef_ready = 1'b0;
    w_byte_valid = 1'b0;
    w_start_go   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = RUN;
          w_start_go   = 1'b1;
        end
      end
      RUN: begin
        // Intake and output are mutually exclusive via the 8-bit threshold.
        w_coef_ready = (w_bitcnt < BCNT_W'(8)) && !w_all_in;
        w_byte_valid = (w_bitcnt >= BCNT_W'(8));
        if (w_all_in && (w_bitcnt < BCNT_W'(8))) begin
          w_state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (w_bitcnt == '0) begin
          w_state_next = FIN;
        end else begin
          w_byte_valid = 1'b1;
          if (bus.byte_ready) begin
            w_state_next = FIN;
          end
        end
      end
      FIN: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_coef_acc  = w_coef_ready && bus.coef_valid;
  assign w_byte_hs   = w_byte_valid && bus.byte_ready;
  // The last coefficient is implied by the zero-sum property and not packed.
  assign w_load      = w_coef_acc && (r_coef_cnt < CNT_W'(N - 1));
  assign w_enter_fin = (r_state == FLUSH) && (w_state_next == FIN);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Coefficient/byte counters, running sum and the latched sum check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coef_cnt <= '0;
      r_byte_cnt <= '0;
      r_sum      <= '0;
      r_sum_ok   <= 1'b0;
    end else if (w_start_go) begin
      r_coef_cnt <= '0;
      r_byte_cnt <= '0;
      r_sum      <= '0;
      r_sum_ok   <= 1'b0;
    end else begin
      if (w_coef_acc) begin
        r_coef_cnt <= r_coef_cnt + CNT_W'(1);
        r_sum      <= r_sum + bus.coef;
      end
      if (w_byte_hs) begin
        r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
      end
      if (w_enter_fin) begin
        r_sum_ok <= (r_sum == '0);
      end
    end
  end

  pack_bitbuf u_bitbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_start_go),
    .i_load   (w_load),
    .i_data   (bus.coef),
    .i_shift8 (w_byte_hs),
    .o_byte   (w_buf_byte),
    .o_bitcnt (w_bitcnt)
  );

  assign bus.coef_ready = w_coef_ready;
  assign bus.byte_valid = w_byte_valid;
  assign bus.byte_out   = w_byte_valid ? w_buf_byte : 8'h00;
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == FIN);
  assign bus.sum_ok     = r_sum_ok;

  // Every completed job must have emitted exactly the packed length.
  a_byte_total: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == FIN) |-> (r_byte_cnt == BYTE_CNT_W'(PACK_BYTES)));
endmodule

// File: tb/tb_pack_rq0.sv
// Bench for pack_rq0: directed vector table plus randomized jobs checked
// against a bit-stream reference model and an unpack round-trip.
module tb_pack_rq0;
  import pack_rq0_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pack_rq0_if bus();

  pack_rq0 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [LOGQ-1:0] coefs [N];
  logic [7:0]      exp_bytes [PACK_BYTES];
  logic            exp_ok;
  logic [7:0]      got_q [$];
  int              done_cnt;
  logic            sum_ok_seen;
  int              stall_bad;
  bit              aborted;

  typedef struct {
    int              i0; logic [LOGQ-1:0] v0;
    int              i1; logic [LOGQ-1:0] v1;
    int              i2; logic [LOGQ-1:0] v2;
    int              b0; logic [7:0]      e0;
    int              b1; logic [7:0]      e1;
    int              b2; logic [7:0]      e2;
    logic            ok;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] got_byte(input int i);
    logic [7:0] r;
    r = 8'hxx;
    if (i < got_q.size()) r = got_q[i];
    return r;
  endfunction

  // Reference: place bit j of coefficient k at stream bit k*LOGQ+j, drop the last one.
  function automatic void build_model();
    int s;
    for (int i = 0; i < PACK_BYTES; i++) exp_bytes[i] = 8'h00;
    for (int b = 0; b < (N - 1) * LOGQ; b++) begin
      exp_bytes[b / 8][b % 8] = coefs[b / LOGQ][b % LOGQ];
    end
    s = 0;
    for (int k = 0; k < N; k++) s += int'(coefs[k]);
    exp_ok = ((s % (1 << LOGQ)) == 0);
  endfunction

  task automatic finish_checks(input string tag, input bit stalled);
    int mism;
    chk({tag, "_byte_count"}, got_q.size(), PACK_BYTES);
    chk({tag, "_done_count"}, done_cnt, 1);
    mism = 0;
    for (int i = 0; i < PACK_BYTES; i++) begin
      if (got_byte(i) !== exp_bytes[i]) mism++;
    end
    chk({tag, "_stream_mismatches"}, mism, 0);
    chk({tag, "_sum_ok"}, sum_ok_seen, exp_ok);
    chk({tag, "_sum_ok_hold"}, bus.sum_ok, exp_ok);
    if (stalled) chk({tag, "_stall_stable_violations"}, stall_bad, 0);
  endtask

  task automatic run_job(input string tag, input int vprob, input int stall_at,
                         input int rst_at, input bit restart);
    int idx, cyc, acc_cyc, bv_cyc, stall_left, post;
    bit stall_started, prev_stalled, fin;
    logic [7:0] prev_byte;
    idx = 0; acc_cyc = -1; bv_cyc = -1; stall_left = 0; post = -1;
    stall_started = 0; prev_stalled = 0; fin = 0; prev_byte = 8'h00;
    got_q.delete(); done_cnt = 0; stall_bad = 0; aborted = 0; sum_ok_seen = 1'b0;

    bus.start = 1'b1; bus.coef_valid = 1'b0; bus.byte_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_busy_after_start"}, bus.busy, 1);
    chk({tag, "_sum_ok_cleared"}, bus.sum_ok, 0);

    for (cyc = 0; cyc < 20000 && !fin; cyc++) begin
      bus.coef_valid = (idx < N) && ($urandom_range(99) < vprob);
      bus.coef = bus.coef_valid ? coefs[idx] : LOGQ'($urandom);
      if (!stall_started && stall_at >= 0 && got_q.size() == stall_at) begin
        stall_started = 1; stall_left = 10;
      end
      bus.byte_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      bus.start = restart && (done_cnt == 0) && (cyc % 400 == 50);
      #1;
      if (prev_stalled && (!bus.byte_valid || bus.byte_out !== prev_byte)) stall_bad++;
      prev_stalled = bus.byte_valid && !bus.byte_ready;
      prev_byte = bus.byte_out;
      if (bus.done) begin
        done_cnt++;
        sum_ok_seen = bus.sum_ok;
        if (post < 0) post = 2;
      end
      if (bus.byte_valid && bv_cyc < 0) bv_cyc = cyc;
      if (bus.coef_valid && bus.coef_ready) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        idx++;
      end
      if (bus.byte_valid && bus.byte_ready) got_q.push_back(bus.byte_out);
      if (rst_at >= 0 && got_q.size() == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_async_reset_outputs"},
            {bus.coef_ready, bus.byte_valid, bus.byte_out, bus.busy, bus.done, bus.sum_ok}, 0);
        aborted = 1;
        fin = 1;
      end else begin
        if (post == 0) fin = 1;
        else if (post > 0) post--;
        @(posedge clk); #1;
      end
    end
    bus.start = 1'b0; bus.coef_valid = 1'b0; bus.byte_ready = 1'b1;

    if (aborted) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) begin
        @(posedge clk); #1;
        if (bus.done) done_cnt++;
      end
      chk({tag, "_no_done_after_abort"}, done_cnt, 0);
      chk({tag, "_idle_after_abort"}, bus.busy, 0);
    end else if (!fin) begin
      chk({tag, "_job_finished"}, 0, 1);
    end else begin
      chk({tag, "_first_byte_latency"}, bv_cyc - acc_cyc, 1);
      finish_checks(tag, stall_at >= 0);
    end
  endtask

  task automatic check_roundtrip(input string tag);
    int mism, b;
    logic [LOGQ-1:0] c;
    logic [7:0] by;
    mism = 0;
    for (int k = 0; k < N - 1; k++) begin
      for (int j = 0; j < LOGQ; j++) begin
        b = k * LOGQ + j;
        by = got_byte(b / 8);
        c[j] = by[b % 8];
      end
      if (c !== coefs[k]) mism++;
    end
    chk({tag, "_unpack_mismatches"}, mism, 0);
  endtask

  task automatic random_coefs(input bit zero_sum);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) begin
      coefs[k] = LOGQ'($urandom);
      if (k < N - 1) s += int'(coefs[k]);
    end
    if (zero_sum) coefs[N - 1] = LOGQ'((1 << LOGQ) - (s % (1 << LOGQ)));
  endtask

  initial begin
    // Directed vectors: coefficient overrides and hand-derived bytes / sum check.
    // Row 1: 0x1FFF + 0x0001 + 0x1FFE = 0x3FFE, which is 0x1FFE mod 2^13, so not zero.
    tbl[0] = '{-1, 13'h0,    -1, 13'h0,    -1, 13'h0,    0,    8'h00, 569,  8'h00, 1137, 8'h00, 1'b1};
    tbl[1] = '{0,  13'h1FFF, 1,  13'h0001, 700, 13'h1FFE, 0,   8'hFF, 1,    8'h3F, 2,    8'h00, 1'b0};
    tbl[2] = '{699, 13'h1FFF, 700, 13'h0001, -1, 13'h0,  1135, 8'h80, 1136, 8'hFF, 1137, 8'h0F, 1'b1};
    tbl[3] = '{699, 13'h1FFF, 700, 13'h0000, -1, 13'h0,  1135, 8'h80, 1136, 8'hFF, 1137, 8'h0F, 1'b0};

    bus.start = 1'b0; bus.coef_valid = 1'b0; bus.coef = '0; bus.byte_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {bus.coef_ready, bus.byte_valid, bus.byte_out, bus.busy, bus.done, bus.sum_ok}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset",
        {bus.coef_ready, bus.byte_valid, bus.byte_out, bus.busy, bus.done, bus.sum_ok}, 0);

    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < N; k++) coefs[k] = '0;
      if (tbl[t].i0 >= 0) coefs[tbl[t].i0] = tbl[t].v0;
      if (tbl[t].i1 >= 0) coefs[tbl[t].i1] = tbl[t].v1;
      if (tbl[t].i2 >= 0) coefs[tbl[t].i2] = tbl[t].v2;
      build_model();
      run_job($sformatf("tbl%0d", t), 100, -1, -1, 1'b0);
      $display("vector %0d: bytes=%0d done=%0d sum_ok=%0b", t, got_q.size(), done_cnt, sum_ok_seen);
      chk($sformatf("tbl%0d_byte%0d", t, tbl[t].b0), got_byte(tbl[t].b0), tbl[t].e0);
      chk($sformatf("tbl%0d_byte%0d", t, tbl[t].b1), got_byte(tbl[t].b1), tbl[t].e1);
      chk($sformatf("tbl%0d_byte%0d", t, tbl[t].b2), got_byte(tbl[t].b2), tbl[t].e2);
      chk($sformatf("tbl%0d_sum_ok_vector", t), sum_ok_seen, tbl[t].ok);
    end

    // Random zero-sum job with a 10-cycle output stall at byte 500.
    random_coefs(1'b1);
    build_model();
    run_job("rand_stall", 60, 500, -1, 1'b0);
    $display("random stall job: bytes=%0d done=%0d sum_ok=%0b", got_q.size(), done_cnt, sum_ok_seen);
    check_roundtrip("rand_stall");

    // Random job with an arbitrary last coefficient and sparse intake.
    random_coefs(1'b0);
    build_model();
    run_job("rand_sparse", 30, 200, -1, 1'b0);
    $display("random sparse job: bytes=%0d done=%0d sum_ok=%0b", got_q.size(), done_cnt, sum_ok_seen);
    check_roundtrip("rand_sparse");

    // Abort at byte 300, then a clean full job on the same data.
    random_coefs(1'b1);
    build_model();
    run_job("abort", 80, -1, 300, 1'b0);
    $display("abort job: bytes_before_reset=%0d", got_q.size());
    run_job("after_abort", 100, -1, -1, 1'b0);
    $display("post-abort job: bytes=%0d done=%0d sum_ok=%0b", got_q.size(), done_cnt, sum_ok_seen);

    // start pulses while busy must be ignored.
    random_coefs(1'b1);
    build_model();
    run_job("restart", 100, -1, -1, 1'b1);
    $display("restart job: bytes=%0d done=%0d sum_ok=%0b", got_q.size(), done_cnt, sum_ok_seen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
